pitch_track_sequencer: RTL and testbench

//  Sequences one pitch estimate per FFT frame. Scans the FFT bin stream for the

---
 rtl/pitch_track_sequencer.sv | 136 +++++++++++++
 tb/tb_pitch_track_sequencer.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pitch_track_sequencer.sv
// Finds the peak in-window FFT bin per frame, runs freq_estimator on it and holds the result.
// Latency: last bin -> est_start 2 cycles, est_done -> freq_valid 1 cycle; no backpressure (bins must be accepted every cycle).
module pitch_track_sequencer #(
  parameter int          N_BINS    = 512,
  parameter int          MIN_INDEX = 2,
  parameter int          MAX_INDEX = 255,
  parameter logic [31:0] MIN_MAG   = 32'h0000_1000,
  parameter int          TIMEOUT   = 1024
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      frame_start,
  input  logic                      bin_valid,
  input  logic [$clog2(N_BINS)-1:0] bin_index,
  input  logic [31:0]               bin_mag,
  input  logic [31:0]               bin_phase,
  output logic                      est_start,
  output logic [31:0]               est_max_phase,
  output logic [$clog2(N_BINS)-1:0] est_max_index,
  input  logic                      est_done,
  input  logic [31:0]               est_frequency,
  output logic [31:0]               freq_out,
  output logic                      freq_valid,
  output logic                      no_pitch,
  output logic                      timeout_err,
  output logic                      busy
);

  localparam int IDX_W = $clog2(N_BINS);
  localparam int CNT_W = $clog2(TIMEOUT);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_BINS - 1);
  localparam logic [IDX_W-1:0] MIN_IDX  = IDX_W'(MIN_INDEX);
  localparam logic [IDX_W-1:0] MAX_IDX  = IDX_W'(MAX_INDEX);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_SCAN, ST_START, ST_WAIT} state_t;

  state_t           state, state_nxt;
  logic [31:0]      best_mag, best_phase;
  logic [IDX_W-1:0] best_index;
  logic [CNT_W-1:0] wait_cnt;
  logic [31:0]      scan_peak;
  logic             clr_best, upd_best, np_set, start_set, fv_set, to_set;

  always_comb begin
    state_nxt = state;
    clr_best  = 1'b0;
    upd_best  = 1'b0;
    np_set    = 1'b0;
    start_set = 1'b0;
    fv_set    = 1'b0;
    to_set    = 1'b0;
    scan_peak = best_mag;
    case (state)
      ST_IDLE: begin
        if (frame_start) begin
          clr_best  = 1'b1;
          state_nxt = ST_SCAN;
        end
      end
      ST_SCAN: begin
        if (frame_start) begin
          clr_best = 1'b1;
        end else if (bin_valid) begin
          // Strict compare keeps the lowest index on equal magnitudes.
          if (bin_index >= MIN_IDX && bin_index <= MAX_IDX && bin_mag > best_mag) begin
            upd_best  = 1'b1;
            scan_peak = bin_mag;
          end
          if (bin_index == LAST_IDX) begin
            if (scan_peak < MIN_MAG) begin
              np_set    = 1'b1;
              state_nxt = ST_IDLE;
            end else begin
              state_nxt = ST_START;
            end
          end
        end
      end
      ST_START: begin
        start_set = 1'b1;
        state_nxt = ST_WAIT;
      end
      ST_WAIT: begin
        // A done arriving on the last counted cycle still wins over the timeout.
        if (est_done) begin
          fv_set    = 1'b1;
          state_nxt = ST_IDLE;
        end else if (wait_cnt == CNT_LAST) begin
          to_set    = 1'b1;
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= ST_IDLE;
      best_mag    <= '0;
      best_index  <= '0;
      best_phase  <= '0;
      wait_cnt    <= '0;
      est_start   <= 1'b0;
      no_pitch    <= 1'b0;
      freq_valid  <= 1'b0;
      freq_out    <= '0;
      timeout_err <= 1'b0;
    end else begin
      state      <= state_nxt;
      est_start  <= start_set;
      no_pitch   <= np_set;
      freq_valid <= fv_set;
      if (fv_set) freq_out <= est_frequency;
      if (to_set) timeout_err <= 1'b1;
      if (clr_best) begin
        best_mag   <= '0;
        best_index <= '0;
        best_phase <= '0;
      end else if (upd_best) begin
        best_mag   <= bin_mag;
        best_index <= bin_index;
        best_phase <= bin_phase;
      end
      if (state == ST_START) wait_cnt <= '0;
      else if (state == ST_WAIT) wait_cnt <= wait_cnt + CNT_W'(1);
    end
  end

  // best_* only move in IDLE/SCAN, so the estimator inputs hold steady through START and WAIT.
  assign est_max_phase = best_phase;
  assign est_max_index = best_index;
  assign busy          = (state != ST_IDLE);

endmodule

// File: tb/tb_pitch_track_sequencer.sv
// Bench for pitch_track_sequencer: frame-level peak model feeds a scoreboard checked by an output monitor.
module tb_pitch_track_sequencer;
  localparam int          N_BINS    = 512;
  localparam int          MIN_INDEX = 2;
  localparam int          MAX_INDEX = 255;
  localparam logic [31:0] MIN_MAG   = 32'h0000_1000;
  localparam int          TIMEOUT   = 1024;

  logic        clk = 1'b0;
  logic        reset, frame_start, bin_valid, est_done;
  logic [8:0]  bin_index, est_max_index;
  logic [31:0] bin_mag, bin_phase, est_max_phase, est_frequency, freq_out;
  logic        est_start, freq_valid, no_pitch, timeout_err, busy;

  always #5 clk = ~clk;

  pitch_track_sequencer #(
    .N_BINS(N_BINS), .MIN_INDEX(MIN_INDEX), .MAX_INDEX(MAX_INDEX),
    .MIN_MAG(MIN_MAG), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .reset(reset), .frame_start(frame_start), .bin_valid(bin_valid),
    .bin_index(bin_index), .bin_mag(bin_mag), .bin_phase(bin_phase),
    .est_start(est_start), .est_max_phase(est_max_phase), .est_max_index(est_max_index),
    .est_done(est_done), .est_frequency(est_frequency), .freq_out(freq_out),
    .freq_valid(freq_valid), .no_pitch(no_pitch), .timeout_err(timeout_err), .busy(busy)
  );

  typedef struct {
    int          kind;   // 0 est_start, 1 freq_valid, 2 no_pitch
    logic [8:0]  idx;
    logic [31:0] val;
  } ev_t;

  ev_t         exp_q[$];
  int          checks = 0;
  int          errors = 0;
  logic [31:0] mag_a[N_BINS];
  logic [31:0] ph_a[N_BINS];
  logic [31:0] last_freq = 32'd0;
  logic        exp_err = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic mon_ev(input int kind, input logic [8:0] idx, input logic [31:0] val, input string name);
    ev_t e;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL %s: unexpected output idx %0d val %h", name, idx, val);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != kind || e.idx !== idx || e.val !== val) begin
        errors++;
        $display("FAIL %s: got kind %0d idx %0d val %h expected kind %0d idx %0d val %h",
                 name, kind, idx, val, e.kind, e.idx, e.val);
      end
    end
  endtask

  always @(negedge clk) begin
    if (est_start === 1'b1)  mon_ev(0, est_max_index, est_max_phase, "est_start");
    if (freq_valid === 1'b1) mon_ev(1, 9'd0, freq_out, "freq_valid");
    if (no_pitch === 1'b1)   mon_ev(2, 9'd0, 32'd0, "no_pitch");
  end

  // Reference: first maximum over the allowed window; below threshold means no pitch.
  task automatic model_peak(output bit np, output logic [8:0] bi, output logic [31:0] bp);
    logic [31:0] bm;
    bm = 32'd0; bi = 9'd0; bp = 32'd0;
    for (int i = MIN_INDEX; i <= MAX_INDEX; i++)
      if (mag_a[i] > bm) begin
        bm = mag_a[i]; bi = 9'(i); bp = ph_a[i];
      end
    np = (bm < MIN_MAG);
  endtask

  task automatic set_bg(input logic [31:0] lo, input logic [31:0] hi);
    for (int i = 0; i < N_BINS; i++) begin
      mag_a[i] = $urandom_range(hi, lo);
      ph_a[i]  = $urandom;
    end
  endtask

  task automatic pulse_fs();
    @(negedge clk); frame_start = 1'b1;
    @(negedge clk); frame_start = 1'b0;
  endtask

  task automatic stream(input int hi);
    for (int i = 0; i <= hi; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        @(negedge clk);
        bin_valid = 1'b0; bin_index = 9'($urandom); bin_mag = $urandom;
      end
      @(negedge clk);
      bin_valid = 1'b1; bin_index = 9'(i); bin_mag = mag_a[i]; bin_phase = ph_a[i];
    end
    @(negedge clk); bin_valid = 1'b0;
  endtask

  // mode: 0 done after delay, 1 never done, 2 reset in WAIT, 3 done with frame_start during WAIT
  task automatic run_frame(input int mode, input int delay, input logic [31:0] freq);
    bit          np;
    logic [8:0]  bi;
    logic [31:0] bp;
    int          n;
    model_peak(np, bi, bp);
    if (np) exp_q.push_back('{2, 9'd0, 32'd0});
    else    exp_q.push_back('{0, bi, bp});
    pulse_fs();
    stream(N_BINS - 1);
    if (np) begin
      repeat (3) @(negedge clk);
      chk("np_busy", busy, 0);
      chk("np_freq_held", freq_out, last_freq);
      return;
    end
    n = 0;
    do begin @(negedge clk); n++; end while (est_start !== 1'b1 && n < 10);
    chk("start_latency", n, 1);
    if (est_start !== 1'b1) return;
    chk("busy_in_wait", busy, 1);
    case (mode)
      1: begin
        repeat (TIMEOUT - 4) @(negedge clk);
        chk("pre_timeout_busy", busy, 1);
        chk("pre_timeout_err", timeout_err, exp_err);
        repeat (10) @(negedge clk);
        exp_err = 1'b1;
        chk("timeout_err", timeout_err, 1);
        chk("timeout_busy", busy, 0);
        chk("timeout_freq_held", freq_out, last_freq);
      end
      2: begin
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk); reset = 1'b0;
        chk("rst_est_start", est_start, 0);
        chk("rst_freq_out", freq_out, 0);
        chk("rst_freq_valid", freq_valid, 0);
        chk("rst_no_pitch", no_pitch, 0);
        chk("rst_timeout_err", timeout_err, 0);
        chk("rst_busy", busy, 0);
        chk("rst_max_index", est_max_index, 0);
        chk("rst_max_phase", est_max_phase, 0);
        last_freq = 32'd0; exp_err = 1'b0;
        repeat (2) @(negedge clk);
        est_done = 1'b1; est_frequency = 32'hDEAD_BEEF;
        @(negedge clk); est_done = 1'b0;
        repeat (3) @(negedge clk);
        chk("post_rst_freq_out", freq_out, 0);
        chk("post_rst_busy", busy, 0);
      end
      default: begin
        if (mode == 3) begin
          pulse_fs();
          repeat (delay - 2) @(negedge clk);
        end else begin
          repeat (delay) @(negedge clk);
        end
        exp_q.push_back('{1, 9'd0, freq});
        est_done = 1'b1; est_frequency = freq;
        @(negedge clk); est_done = 1'b0; est_frequency = $urandom;
        last_freq = freq;
        @(negedge clk);
        chk("done_freq_out", freq_out, freq);
        chk("done_busy", busy, 0);
        chk("done_timeout_err", timeout_err, exp_err);
      end
    endcase
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; frame_start = 1'b0; bin_valid = 1'b0; est_done = 1'b0;
    bin_index = 9'd0; bin_mag = 32'd0; bin_phase = 32'd0; est_frequency = 32'd0;
    repeat (3) @(negedge clk);
    chk("reset_busy", busy, 0);
    chk("reset_freq_out", freq_out, 0);
    chk("reset_timeout_err", timeout_err, 0);
    chk("reset_est_start", est_start, 0);
    reset = 1'b0;

    set_bg(32'h10, 32'h10);
    mag_a[253] = 32'h8000; ph_a[253] = 32'h0010_0000;
    run_frame(0, 5, 32'h1B80_0000);

    set_bg(32'h0, 32'hFF);
    mag_a[10] = 32'h9000; mag_a[20] = 32'h9000;
    mag_a[0] = 32'hFFFF_FFFF; mag_a[300] = 32'hFFFF_FFFF;
    run_frame(0, 3, $urandom);

    set_bg(32'h0FFF, 32'h0FFF);
    run_frame(0, 3, $urandom);

    // Peak exactly at threshold, done on the final counted WAIT cycle.
    set_bg(32'h1000, 32'h1000);
    run_frame(0, TIMEOUT - 1, $urandom);

    set_bg(32'h0, 32'hFF);
    mag_a[1] = 32'hFFFF_FFFF; mag_a[256] = 32'hFFFF_FFFF; mag_a[511] = 32'hFFFF_FFFF;
    mag_a[2] = 32'h1FFF; mag_a[255] = 32'h2000;
    run_frame(0, 2, $urandom);

    set_bg(32'h0, 32'hFFFF);
    run_frame(1, 0, 32'd0);
    set_bg(32'h0, 32'hFFFF_FFFF);
    run_frame(0, 4, $urandom);

    set_bg(32'h0, 32'hFF);
    mag_a[40] = 32'h5_0000;
    pulse_fs();
    stream(50);
    mag_a[40] = 32'h10; mag_a[60] = 32'h2_0000;
    run_frame(3, 6, $urandom);

    set_bg(32'h0, 32'hFFFF);
    run_frame(2, 0, 32'd0);

    for (int f = 0; f < 8; f++) begin
      case ($urandom_range(0, 2))
        0: set_bg(32'h0, 32'hFFFF_FFFF);
        1: for (int i = 0; i < N_BINS; i++) begin
             mag_a[i] = 32'($urandom_range(0, 15)) << 12; ph_a[i] = $urandom;
           end
        default: begin
          set_bg(32'h0, 32'h0FFF);
          mag_a[$urandom_range(0, 1)] = 32'hFFFF_FFFF;
          mag_a[$urandom_range(256, 511)] = 32'hFFFF_FFFF;
        end
      endcase
      if ($urandom_range(0, 3) == 0) run_frame(3, $urandom_range(3, 30), $urandom);
      else                           run_frame(0, $urandom_range(1, 40), $urandom);
    end

    repeat (5) @(negedge clk);
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
